spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter FRAME_BITS, default 16: SCLK rising edges per complete frame; only the value 16 is required to be supported.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop stages in each input synchronizer.
REQ-003 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 nCS  input  1  asynchronous active-low chip select from the SPI master.
REQ-006 SCLK  input  1  asynchronous SPI clock (mode 0: idle low, master samples DOUT on rising edge).
REQ-007 DIN  input  1  asynchronous serial data from the master, MSB first.
REQ-008 DOUT  output  1  serial data to the master, MSB first; always driven, never tristated.
REQ-009 rx_data  output  16  last completely received DIN word.
REQ-010 frame_valid  output  1  one-sys_clk pulse when rx_data updates.

Function
REQ-011 nCS, SCLK and DIN each pass through a SYNC_STAGES-deep synchronizer; SCLK edges are detected on synchronized values only.
REQ-012 Supported SCLK: each SCLK high and low phase lasts at least 4 sys_clk periods; faster SCLK is out of scope.
REQ-013 Synchronized nCS falling: load tx shift register with the tx word; bit counter = 0; DOUT = tx word bit 15.
REQ-014 Synchronized SCLK rising with nCS low and bit counter < 16: shift synchronized DIN into rx shift register LSB; bit counter increments.
REQ-015 Synchronized SCLK falling with nCS low and bit counter in 1..15: DOUT = next tx bit (bit 15 minus bit counter).
REQ-016 DOUT updates at most SYNC_STAGES+1 sys_clk cycles after a pin-level SCLK falling edge.
REQ-017 16th rising edge: rx_data = received word; frame_valid pulses high for one cycle at the same clock edge.
REQ-018 Same completion edge: channel register = received bits [13:11], taking effect for the next frame; sample counter increments.
REQ-019 tx word = {4'b0000, channel[2:0], sample_counter[8:0]}.
REQ-020 Sample counter is 9 bits; it wraps from 511 to 0.
REQ-021 SCLK edges after the 16th within one frame are ignored; DOUT = 0 after bit 0 has been presented and until the next frame.
REQ-022 DOUT = 0 whenever synchronized nCS is high.
REQ-023 nCS rising before 16 rising edges aborts the frame: no frame_valid; rx_data, channel and counter unchanged; bit counter = 0.
REQ-024 SCLK edges while nCS is high have no effect.

Reset
REQ-025 rst high at a sys_clk edge sets DOUT = 0, rx_data = 0, frame_valid = 0, channel = 0, sample counter = 0, bit counter = 0, shift registers = 0 and synchronizers to idle (nCS = 1, SCLK = 0, DIN = 0).
REQ-026 Reset mid-frame discards the frame; the slave waits for a new nCS falling edge after rst is released.

Configuration
REQ-027 Macro SPI_SLAVE_LOOPBACK_EN defined: tx word = current rx_data, which is 0 after reset; channel and counter still update but do not affect DOUT.
REQ-028 Macro SPI_SLAVE_LOOPBACK_EN undefined: tx word per REQ-019.

Verification
REQ-029 After reset, frame with DIN 0x0000 -> DOUT word 0x0000; rx_data 0x0000; one frame_valid pulse.
REQ-030 Frames 2 and 3 with DIN 0x1800 -> frame 2 DOUT 0x0001, frame 3 DOUT 0x0602 (channel 3, count 2).
REQ-031 nCS raised after 7 SCLK edges, then a full frame -> no pulse for the aborted frame; full frame returns the same word as if no abort occurred.
REQ-032 513 consecutive frames with DIN 0x0000 -> frame 513 DOUT 0x0000 (counter wrap).
REQ-033 rst asserted after 9 bits, then a fresh frame -> DOUT 0x0000; rx_data 0; no frame_valid before the fresh frame completes.
REQ-034 SPI_SLAVE_LOOPBACK_EN defined, frame DIN 0xA5C3 then frame DIN 0x0000 -> second frame DOUT 0xA5C3.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI pin bundle and received-word outputs shared by the master side and spi_slave.
interface spi_slave_if;
    logic        nCS;
    logic        SCLK;
    logic        DIN;
    logic        DOUT;
    logic [15:0] rx_data;
    logic        frame_valid;

    modport master (
        output nCS,
        output SCLK,
        output DIN,
        input  DOUT,
        input  rx_data,
        input  frame_valid
    );

    modport slave (
        input  nCS,
        input  SCLK,
        input  DIN,
        output DOUT,
        output rx_data,
        output frame_valid
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled on sys_clk. Receives 16-bit words MSB first and
// returns a status word {4'b0, channel, sample_counter}. Defining the macro
// SPI_SLAVE_LOOPBACK_EN makes the returned word the last received word instead.
module spi_slave #(
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = $clog2(FRAME_BITS + 1);
    localparam int unsigned CHAN_W = 3;
    localparam int unsigned SMP_W  = 9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   ncs_prev_q;
    logic                   sclk_prev_q;

    logic [1:0]        state_q,   state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_sr_q,   rx_sr_d;
    logic [DATA_W-1:0] tx_sr_q,   tx_sr_d;
    logic              dout_q,    dout_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              fv_q,      fv_d;
    logic [CHAN_W-1:0] chan_q,    chan_d;
    logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;

    logic              ncs_s;
    logic              sclk_s;
    logic              din_s;
    logic              ncs_fall_c;
    logic              sclk_rise_c;
    logic              sclk_fall_c;
    logic [DATA_W-1:0] rx_next_c;
    logic [DATA_W-1:0] tx_word_c;

    // Input synchronizers; idle levels are nCS high, SCLK and DIN low
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ncs_sync_q  <= '1;
            sclk_sync_q <= '0;
            din_sync_q  <= '0;
            ncs_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            ncs_sync_q  <= SYNC_STAGES'({ncs_sync_q, bus.nCS});
            sclk_sync_q <= SYNC_STAGES'({sclk_sync_q, bus.SCLK});
            din_sync_q  <= SYNC_STAGES'({din_sync_q, bus.DIN});
            ncs_prev_q  <= ncs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign din_s       = din_sync_q[SYNC_STAGES-1];
    assign ncs_fall_c  = ncs_prev_q & ~ncs_s;
    assign sclk_rise_c = ~sclk_prev_q & sclk_s;
    assign sclk_fall_c = sclk_prev_q & ~sclk_s;
    assign rx_next_c   = {rx_sr_q[DATA_W-2:0], din_s};

`ifdef SPI_SLAVE_LOOPBACK_EN
    assign tx_word_c = rx_data_q;
`else
    assign tx_word_c = {4'b0000, chan_q, smp_cnt_q};
`endif

    // Frame state register and all registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            dout_q    <= 1'b0;
            rx_data_q <= '0;
            fv_q      <= 1'b0;
            chan_q    <= '0;
            smp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            dout_q    <= dout_d;
            rx_data_q <= rx_data_d;
            fv_q      <= fv_d;
            chan_q    <= chan_d;
            smp_cnt_q <= smp_cnt_d;
        end
    end

    // Next-state logic: frame start on nCS fall, shift on SCLK edges, abort on nCS rise
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        dout_d    = dout_q;
        rx_data_d = rx_data_q;
        fv_d      = 1'b0;
        chan_d    = chan_q;
        smp_cnt_d = smp_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (ncs_fall_c) begin
                    state_d   = ST_SHIFT;
                    tx_sr_d   = tx_word_c;
                    rx_sr_d   = '0;
                    bit_cnt_d = '0;
                    dout_d    = tx_word_c[DATA_W-1];
                end
            end
            ST_SHIFT: begin
                if (ncs_s) begin
                    // Early deselect: drop the partial word, keep all visible state
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    dout_d    = 1'b0;
                end else if (sclk_rise_c) begin
                    rx_sr_d   = rx_next_c;
                    bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                    if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        state_d   = ST_DONE;
                        rx_data_d = rx_next_c;
                        fv_d      = 1'b1;
                        chan_d    = rx_next_c[13:11];
                        smp_cnt_d = SMP_W'(smp_cnt_q + 1'b1);
                    end
                end else if (sclk_fall_c && (bit_cnt_q != '0)) begin
                    // Top of tx_sr_q is the bit already on DOUT; present the next one
                    tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                    dout_d  = tx_sr_q[DATA_W-2];
                end
            end
            ST_DONE: begin
                if (ncs_s) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    dout_d    = 1'b0;
                end else if (sclk_fall_c) begin
                    dout_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                dout_d    = 1'b0;
            end
        endcase
    end

    assign bus.DOUT        = dout_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave against a word-level model of channel,
// sample counter and received word.
module tb_spi_slave;

    logic sys_clk = 1'b0;
    logic rst;

    always #5 sys_clk = ~sys_clk;

    spi_slave_if bus ();

    spi_slave #(
        .FRAME_BITS  (16),
        .SYNC_STAGES (2)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Word-level reference state
    logic [2:0]  m_chan;
    logic [8:0]  m_cnt;
    logic [15:0] m_rx;
    int          m_pulses = 0;

    // Observed frame_valid pulses and the rx_data seen with the latest one
    int          fv_cnt = 0;
    logic [15:0] rx_at_pulse = '0;

    logic [15:0] got;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_tx();
`ifdef SPI_SLAVE_LOOPBACK_EN
        return m_rx;
`else
        return {4'b0000, m_chan, m_cnt};
`endif
    endfunction

    always @(negedge sys_clk) begin
        if (bus.frame_valid === 1'b1) begin
            fv_cnt++;
            rx_at_pulse = bus.rx_data;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic int phase(input bit fast);
        return fast ? 4 : int'($urandom_range(4, 7));
    endfunction

    // Master side of one frame: nbits clocked bits plus extra trailing SCLK pulses
    task automatic run_frame(input logic [15:0] din_word, input int nbits, input int extra,
                             input bit fast, input bit raise_ncs, output logic [15:0] rd);
        rd = '0;
        bus.nCS = 1'b0;
        wait_clks(fast ? 5 : int'($urandom_range(5, 10)));
        for (int i = 0; i < nbits + extra; i++) begin
            bus.DIN = (i < 16) ? din_word[15-i] : 1'($urandom);
            wait_clks(phase(fast));
            bus.SCLK = 1'b1;
            if (i < 16) rd[15-i] = bus.DOUT;
            else        check_eq("dout_after_frame", 32'(bus.DOUT), 32'd0);
            wait_clks(phase(fast));
            bus.SCLK = 1'b0;
        end
        if (raise_ncs) begin
            wait_clks(phase(fast));
            bus.nCS = 1'b1;
            wait_clks(phase(fast));
            check_eq("dout_idle", 32'(bus.DOUT), 32'd0);
        end
    endtask

    task automatic full_frame(input logic [15:0] din_word, input int extra, input bit fast,
                              output logic [15:0] rd);
        logic [15:0] exp;
        exp = exp_tx();
        run_frame(din_word, 16, extra, fast, 1'b1, rd);
        check_eq("dout_word", 32'(rd), 32'(exp));
        m_rx   = din_word;
        m_chan = din_word[13:11];
        m_cnt  = m_cnt + 9'd1;
        m_pulses++;
        check_eq("fv_pulses", 32'(fv_cnt), 32'(m_pulses));
        check_eq("rx_at_pulse", 32'(rx_at_pulse), 32'(din_word));
        check_eq("rx_data", 32'(bus.rx_data), 32'(m_rx));
    endtask

    task automatic abort_frame(input logic [15:0] din_word, input int nbits);
        logic [15:0] exp;
        logic [15:0] rd;
        exp = exp_tx();
        run_frame(din_word, nbits, 0, 1'b0, 1'b1, rd);
        check_eq("dout_partial", 32'(rd >> (16 - nbits)), 32'(exp >> (16 - nbits)));
        check_eq("abort_no_pulse", 32'(fv_cnt), 32'(m_pulses));
        check_eq("abort_rx_kept", 32'(bus.rx_data), 32'(m_rx));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.nCS  = 1'b1;
        bus.SCLK = 1'b0;
        bus.DIN  = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(4);
        m_chan = '0;
        m_cnt  = '0;
        m_rx   = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.nCS  = 1'b1;
        bus.SCLK = 1'b0;
        bus.DIN  = 1'b0;
        do_reset();

        check_eq("reset_dout", 32'(bus.DOUT), 32'd0);
        check_eq("reset_rx_data", 32'(bus.rx_data), 32'd0);
        check_eq("reset_frame_valid", 32'(bus.frame_valid), 32'd0);

        full_frame(16'h0000, 0, 1'b0, got);
        check_eq("first_frame_dout", 32'(got), 32'h0000);
        check_eq("first_frame_pulse", 32'(fv_cnt), 32'd1);

`ifdef SPI_SLAVE_LOOPBACK_EN
        full_frame(16'hA5C3, 0, 1'b0, got);
        full_frame(16'h0000, 0, 1'b0, got);
        check_eq("loopback_word", 32'(got), 32'hA5C3);
`else
        full_frame(16'h1800, 0, 1'b0, got);
        check_eq("frame2_dout", 32'(got), 32'h0001);
        full_frame(16'h1800, 0, 1'b0, got);
        check_eq("frame3_dout", 32'(got), 32'h0602);
`endif

        abort_frame(16'($urandom), 7);
        full_frame(16'($urandom), 0, 1'b0, got);

        repeat (40) begin
            if ($urandom_range(0, 4) == 0)
                abort_frame(16'($urandom), int'($urandom_range(1, 15)));
            else
                full_frame(16'($urandom), int'($urandom_range(0, 2)), 1'b0, got);
        end

        // Reset in the middle of a frame, with nCS released while reset is held
        run_frame(16'($urandom), 9, 0, 1'b0, 1'b0, got);
        do_reset();
        check_eq("midreset_rx_data", 32'(bus.rx_data), 32'd0);
        check_eq("midreset_dout", 32'(bus.DOUT), 32'd0);
        check_eq("midreset_no_pulse", 32'(fv_cnt), 32'(m_pulses));
        full_frame(16'($urandom), 0, 1'b0, got);
        check_eq("fresh_frame_dout", 32'(got), 32'h0000);

        do_reset();
        for (int k = 0; k < 513; k++) full_frame(16'h0000, 0, 1'b1, got);
        check_eq("wrap_frame513_dout", 32'(got), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
